// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: segment bit order and the logical
// (active-high) glyph patterns used by the decoder.
package sevenseg_pkg;

    localparam int SEG_W = 7;

    // Bit 6 is segment a, bit 0 is segment g; a packed struct makes the order explicit.
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
    } seg_bits_t;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t GLYPH_0     = 7'b1111110;
    localparam seg_t GLYPH_1     = 7'b0110000;
    localparam seg_t GLYPH_2     = 7'b1101101;
    localparam seg_t GLYPH_3     = 7'b1111001;
    localparam seg_t GLYPH_4     = 7'b0110011;
    localparam seg_t GLYPH_5     = 7'b1011011;
    localparam seg_t GLYPH_6     = 7'b1011111;
    localparam seg_t GLYPH_7     = 7'b1110000;
    localparam seg_t GLYPH_8     = 7'b1111111;
    localparam seg_t GLYPH_9     = 7'b1110011;
    localparam seg_t GLYPH_A     = 7'b1110111;
    localparam seg_t GLYPH_B     = 7'b0011111;
    localparam seg_t GLYPH_C     = 7'b1001110;
    localparam seg_t GLYPH_D     = 7'b0111101;
    localparam seg_t GLYPH_E     = 7'b1001111;
    localparam seg_t GLYPH_F     = 7'b1000111;
    localparam seg_t GLYPH_BLANK = 7'b0000000;

endpackage

// File: rtl/sevenseg_glyph_decoder.sv
// Combinational nibble-to-glyph decoder; HEX_MODE=0 renders 10..15 as "0".
module sevenseg_glyph_decoder
    import sevenseg_pkg::*;
#(
    parameter int HEX_MODE = 1
) (
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    // Glyph lookup
    always_comb begin
        seg_o = GLYPH_BLANK;
        case (nibble_i)
            4'h0:    seg_o = GLYPH_0;
            4'h1:    seg_o = GLYPH_1;
            4'h2:    seg_o = GLYPH_2;
            4'h3:    seg_o = GLYPH_3;
            4'h4:    seg_o = GLYPH_4;
            4'h5:    seg_o = GLYPH_5;
            4'h6:    seg_o = GLYPH_6;
            4'h7:    seg_o = GLYPH_7;
            4'h8:    seg_o = GLYPH_8;
            4'h9:    seg_o = GLYPH_9;
            4'hA:    seg_o = (HEX_MODE != 0) ? GLYPH_A : GLYPH_0;
            4'hB:    seg_o = (HEX_MODE != 0) ? GLYPH_B : GLYPH_0;
            4'hC:    seg_o = (HEX_MODE != 0) ? GLYPH_C : GLYPH_0;
            4'hD:    seg_o = (HEX_MODE != 0) ? GLYPH_D : GLYPH_0;
            4'hE:    seg_o = (HEX_MODE != 0) ? GLYPH_E : GLYPH_0;
            4'hF:    seg_o = (HEX_MODE != 0) ? GLYPH_F : GLYPH_0;
            default: seg_o = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/sevenseg_mux_driver.sv
// Multiplexed seven-segment driver with double-buffered digit data, guard
// blanking between digit slots and optional leading-zero blanking.
module sevenseg_mux_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int HEX_MODE       = 1,
    parameter int ACTIVE_LOW_SEG = 0,
    parameter int ACTIVE_LOW_DIG = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    input  logic                    lzb,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam seg_t                  SEG_INV = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_INV  = (ACTIVE_LOW_SEG != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] DIG_INV = (ACTIVE_LOW_DIG != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
    seg_t                    seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    tick_q, tick_d;

    logic       cnt_wrap_s, boundary_s, vis_s, lit_s;
    logic [3:0] cur_nib_s;
    logic       cur_dp_s, cur_en_s, cur_zero_blank_s;
    seg_t       glyph_s;

    // Slot counter and digit index sequencing
    always_comb begin
        cnt_wrap_s = (cnt_q == CNT_MAX);
        boundary_s = cnt_wrap_s && (idx_q == IDX_MAX);
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        if (cnt_wrap_s) begin
            cnt_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Double buffer: the active copy only changes on a frame boundary
    always_comb begin
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_en_d   = pend_en_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_en_d    = act_en_q;
        if (boundary_s) begin
            pend_d = 1'b0;
            if (load) begin
                act_data_d = data_in;
                act_dp_d   = dp_in;
                act_en_d   = digit_en;
            end else if (pend_q) begin
                act_data_d = pend_data_q;
                act_dp_d   = pend_dp_q;
                act_en_d   = pend_en_q;
            end else begin
                act_data_d = act_data_q;
            end
        end else if (load) begin
            pend_d      = 1'b1;
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            pend_en_d   = digit_en;
        end else begin
            pend_d = pend_q;
        end
    end

    // Current-digit selection; the zero run is tracked from the top digit downwards
    always_comb begin
        logic zero_run;
        zero_run         = lzb;
        cur_nib_s        = 4'h0;
        cur_dp_s         = 1'b0;
        cur_en_s         = 1'b0;
        cur_zero_blank_s = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (act_data_q[4*k +: 4] == 4'h0);
            if (idx_q == IDX_W'(k)) begin
                cur_nib_s        = act_data_q[4*k +: 4];
                cur_dp_s         = act_dp_q[k];
                cur_en_s         = act_en_q[k];
                cur_zero_blank_s = zero_run && (k != 0);
            end else begin
                cur_zero_blank_s = cur_zero_blank_s;
            end
        end
    end

    sevenseg_glyph_decoder #(
        .HEX_MODE (HEX_MODE)
    ) u_decoder (
        .nibble_i (cur_nib_s),
        .seg_o    (glyph_s)
    );

    // Logical (active-high) next output values
    always_comb begin
        vis_s  = (cnt_q >= CNT_BLANK);
        lit_s  = vis_s && cur_en_s && !cur_zero_blank_s;
        tick_d = boundary_s;
        dp_d   = lit_s && cur_dp_s;
        if (lit_s) begin
            seg_d = glyph_s;
        end else begin
            seg_d = GLYPH_BLANK;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            dig_d[k] = vis_s && (idx_q == IDX_W'(k));
        end
    end

    // State and output registers; pin polarity is applied here only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_en_q   <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_en_q    <= '0;
            seg_q       <= SEG_INV;
            dp_q        <= DP_INV;
            dig_q       <= DIG_INV;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_en_q   <= pend_en_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_en_q    <= act_en_d;
            seg_q       <= seg_d ^ SEG_INV;
            dp_q        <= dp_d ^ DP_INV;
            dig_q       <= dig_d ^ DIG_INV;
            tick_q      <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp_out     = dp_q;
    assign dig_sel    = dig_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Directed bench: 4 digits, 8-cycle slots, 2 guard cycles; a second instance
// checks HEX_MODE=0 with inverted segment and digit pins.
module tb_sevenseg_mux_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        load;
    logic        lzb;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  dig_a, dig_b;
    logic        tick_a, tick_b;

    int n_checks = 0;
    int n_errors = 0;
    int s = 0;
    int on_cnt = 0;

    sevenseg_mux_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
        .HEX_MODE(1), .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_DIG(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
        .digit_en(digit_en), .load(load), .lzb(lzb),
        .seg(seg_a), .dp_out(dp_a), .dig_sel(dig_a), .frame_tick(tick_a)
    );

    sevenseg_mux_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
        .HEX_MODE(0), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_DIG(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
        .digit_en(digit_en), .load(load), .lzb(lzb),
        .seg(seg_b), .dp_out(dp_b), .dig_sel(dig_b), .frame_tick(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance until t rising edges have passed since reset release, then settle.
    // Outputs then reflect state t-1; inputs driven now are sampled with state t.
    task automatic goto(input int t);
        while (s < t) begin
            @(posedge clk);
            s++;
        end
        #1;
    endtask

    task automatic load_vec(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        data_in  = d;
        dp_in    = dp;
        digit_en = en;
        load     = 1'b1;
        goto(s + 1);
        load     = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        data_in  = 16'h0000;
        dp_in    = 4'h0;
        digit_en = 4'h0;
        load     = 1'b0;
        lzb      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg",  {25'd0, seg_a}, 32'h00);
        check("rst_dig",  {28'd0, dig_a}, 32'h0);
        check("rst_dp",   {31'd0, dp_a},  32'h0);
        check("rst_tick", {31'd0, tick_a}, 32'h0);
        check("rst_seg_b", {25'd0, seg_b}, 32'h7F);
        check("rst_dig_b", {28'd0, dig_b}, 32'hF);
        check("rst_dp_b",  {31'd0, dp_b},  32'h1);

        @(negedge clk);
        rst_n = 1'b1;
        s = 0;

        // Load during frame 0 goes to the pending buffer only
        goto(1);
        load_vec(16'h12AF, 4'b0100, 4'hF);
        goto(10);
        check("f0_guard_dig", {28'd0, dig_a}, 32'h0);
        goto(12);
        check("f0_dig1", {28'd0, dig_a}, 32'h2);
        check("f0_old_blank", {25'd0, seg_a}, 32'h00);
        goto(32);
        check("f0_tick", {31'd0, tick_a}, 32'h1);

        // Frame 1: digit 0 slot, duty count and glyphs
        on_cnt = 0;
        for (int t = 33; t <= 40; t++) begin
            goto(t);
            if (dig_a[0]) on_cnt++;
            if (t == 33) begin
                check("f1_tick_low", {31'd0, tick_a}, 32'h0);
                check("f1_guard", {28'd0, dig_a}, 32'h0);
            end
            if (t == 35) begin
                check("f1_d0_seg", {25'd0, seg_a}, 32'b1000111);
                check("f1_d0_dig", {28'd0, dig_a}, 32'h1);
                check("f1_d0_dp",  {31'd0, dp_a}, 32'h0);
                check("b_d0_seg",  {25'd0, seg_b}, 32'b0000001);
                check("b_d0_dig",  {28'd0, dig_b}, 32'b1110);
                check("b_d0_dp",   {31'd0, dp_b}, 32'h1);
            end
        end
        check("d0_duty", on_cnt, 32'd6);

        // New load mid-frame at idx1/cnt3 must not disturb frame 1
        goto(43);
        load_vec(16'hC345, 4'h0, 4'hF);
        goto(45);
        check("f1_d1_seg", {25'd0, seg_a}, 32'b1110111);
        check("f1_d1_dig", {28'd0, dig_a}, 32'h2);
        goto(56);
        check("f1_d2_seg", {25'd0, seg_a}, 32'b1101101);
        check("f1_d2_dp",  {31'd0, dp_a}, 32'h1);
        goto(59);
        check("f1_d3_seg", {25'd0, seg_a}, 32'b0110000);
        check("f1_d3_dig", {28'd0, dig_a}, 32'h8);
        goto(64);
        check("f1_tick", {31'd0, tick_a}, 32'h1);
        goto(67);
        check("f2_d0_seg", {25'd0, seg_a}, 32'b1011011);
        check("b_f2_d0_seg", {25'd0, seg_b}, 32'b0100100);
        goto(76);
        check("f2_d1_seg", {25'd0, seg_a}, 32'b0110011);
        goto(92);
        check("f2_d3_seg", {25'd0, seg_a}, 32'b1001110);
        check("b_hexoff_c", {25'd0, seg_b}, 32'b0000001);
        check("b_f2_d3_dig", {28'd0, dig_b}, 32'b0111);

        // Leading-zero blanking
        goto(93);
        lzb = 1'b1;
        load_vec(16'h0050, 4'h0, 4'hF);
        goto(99);
        check("lzb_d0", {25'd0, seg_a}, 32'b1111110);
        goto(107);
        check("lzb_d1", {25'd0, seg_a}, 32'b1011011);
        goto(115);
        check("lzb_d2_dig", {28'd0, dig_a}, 32'h4);
        check("lzb_d2_seg", {25'd0, seg_a}, 32'h00);
        goto(123);
        check("lzb_d3_dig", {28'd0, dig_a}, 32'h8);
        check("lzb_d3_seg", {25'd0, seg_a}, 32'h00);
        goto(125);
        load_vec(16'h0000, 4'h0, 4'hF);
        goto(131);
        check("lzb0_d0", {25'd0, seg_a}, 32'b1111110);
        goto(139);
        check("lzb0_d1_seg", {25'd0, seg_a}, 32'h00);
        check("lzb0_d1_dig", {28'd0, dig_a}, 32'h2);
        lzb = 1'b0;
        goto(140);
        check("lzb_live_off", {25'd0, seg_a}, 32'b1111110);

        // Load exactly on the frame-boundary cycle
        goto(159);
        load_vec(16'h8888, 4'h0, 4'b1110);
        check("bnd_tick", {31'd0, tick_a}, 32'h1);
        goto(163);
        check("bnd_d0_dig", {28'd0, dig_a}, 32'h1);
        check("bnd_d0_dis", {25'd0, seg_a}, 32'h00);
        goto(171);
        check("bnd_d1_seg", {25'd0, seg_a}, 32'b1111111);
        goto(203);
        check("bnd_next_frame", {25'd0, seg_a}, 32'b1111111);
        goto(213);
        check("pre_rst_dig", {28'd0, dig_a}, 32'h4);
        check("pre_rst_seg", {25'd0, seg_a}, 32'b1111111);

        // Asynchronous reset at idx2/cnt5
        rst_n = 1'b0;
        #1;
        check("mrst_dig", {28'd0, dig_a}, 32'h0);
        check("mrst_seg", {25'd0, seg_a}, 32'h00);
        check("mrst_seg_b", {25'd0, seg_b}, 32'h7F);
        check("mrst_dig_b", {28'd0, dig_b}, 32'hF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s = 0;
        goto(2);
        check("post_guard", {28'd0, dig_a}, 32'h0);
        goto(3);
        check("post_first_dig", {28'd0, dig_a}, 32'h1);
        check("post_cleared", {25'd0, seg_a}, 32'h00);
        goto(12);
        check("post_d1_dig", {28'd0, dig_a}, 32'h2);
        check("post_d1_seg", {25'd0, seg_a}, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
